cacheline_burst_adaptor: RTL and testbench
==========================================

// Module: cacheline_burst_adaptor
// PURPOSE
//  Parametrised bridge between the LLC (one LINE_W-bit line per request) and burst memory (BURST_W bits per beat).
//  Splits write lines into BEATS beats and assembles read beats into a line.
//  Beats may arrive with arbitrary gaps. A no-progress timeout raises an error.
//  Sits between the last-level cache and the physical memory / arbiter port.
// PARAMETERS
//  LINE_W    256  cache line width in bits; must be a multiple of BURST_W
//  BURST_W   64   memory beat width in bits; BEATS = LINE_W/BURST_W (>=2)
//  ADDR_W    32   address width
//  TIMEOUT   1024 max consecutive cycles without resp_i before abort; 0 disables the timeout
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  reset_n    in   1        synchronous, active-low reset
//  line_i     in   LINE_W   write line from LLC; sampled when a write is accepted
//  line_o     out  LINE_W   assembled read line; registered
//  address_i  in   ADDR_W   line address from LLC
//  read_i     in   1        LLC read request; held high until resp_o
//  write_i    in   1        LLC write request; held high until resp_o
//  resp_o     out  1        one-cycle done pulse to LLC
//  err_o      out  1        one-cycle pulse, coincident with resp_o, when a request aborted on timeout
//  burst_i    in   BURST_W  read beat from memory, valid when resp_i=1
//  burst_o    out  BURST_W  write beat to memory
//  address_o  out  ADDR_W   line-aligned address: low log2(LINE_W/8) bits forced to 0
//  read_o     out  1        memory read request
//  write_o    out  1        memory write request
//  resp_i     in   1        memory beat acknowledge; one beat per cycle high
// BEHAVIOUR
//  Reset (reset_n=0 at an edge):
//   - State goes to IDLE; beat counter and timeout counter are cleared.
//   - line_o, burst_o, address_o, read_o, write_o, resp_o and err_o are all 0.
//   - Reset mid-transaction abandons it. No resp_o is produced.
//  States and transitions:
//   - IDLE: samples requests.
//     - read_i=1 goes to RD. Read wins if read_i and write_i are both high.
//     - Otherwise write_i=1 goes to WR.
//     - On acceptance, address_o is latched aligned and the counter is cleared.
//     - For WR, line_i is copied into an internal buffer; later changes to line_i are ignored.
//   - RD: read_o=1.
//     - Each cycle with resp_i=1 writes burst_i into line_o slice [cnt*BURST_W +: BURST_W], then cnt++.
//     - Beat 0 is the LSBs. line_o slices not yet written keep their previous value.
//     - After beat BEATS-1, read_o drops at the next edge and the state goes to DONE.
//   - WR: write_o=1 and burst_o = buffer slice [cnt*BURST_W +: BURST_W].
//     - cnt++ on each resp_i=1. After beat BEATS-1, the state goes to DONE.
//   - DONE: single cycle, resp_o=1, then IDLE. read_i/write_i are ignored in DONE.
//   - Outside RD/WR: read_o, write_o and burst_o are 0.
//  Latency:
//   - Request accepted at edge k: read_o/write_o are high from cycle k+1.
//   - resp_o is high the cycle after the edge that takes the last beat.
//   - Zero-gap read total: BEATS+2 cycles from request to resp_o.
//  Timeout (TIMEOUT>0):
//   - tcnt counts cycles in RD/WR with resp_i=0 and clears on each resp_i=1.
//   - At tcnt==TIMEOUT-1 with resp_i=0: drop read_o/write_o and go to DONE with err_o=1.
//   - On a read timeout, line_o holds the partial data.
//  Widths: cnt is $clog2(BEATS) bits. After the final beat it wraps to 0.
//  resp_i in IDLE/DONE is ignored and does not affect cnt.
//  line_o holds the last completed or aborted line until the next read beat.
// TESTING
//  1. Read, 4 beats, no gaps:
//     read_i=1, address_i=0x1234_5678, burst_i=0x11..,0x22..,0x33..,0x44..
//     -> address_o=0x1234_5660, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o pulse at cycle 6.
//  2. Write with 3-cycle gaps between beats; line_i changed after acceptance
//     -> burst_o shows the original line's 4 slices in order, each held until its resp_i; resp_o once.
//  3. read_i=write_i=1 in IDLE -> read_o=1, write_o=0 throughout; read completes.
//  4. TIMEOUT=8, memory gives 2 beats then silence
//     -> read_o drops 8 cycles after beat 2; resp_o=err_o=1 for one cycle; line_o low 128 bits valid.
//  5. reset_n=0 during write beat 2 -> next cycle all outputs 0, IDLE; a following read works normally.
//  6. BURST_W=32, LINE_W=256 (8 beats) -> 8 beats assembled LSB-first; cnt wraps to 0; resp_o after beat 8.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - LLC line <-> memory burst bridge
// Splits write lines into beats, assembles read beats into a line, aborts on a no-progress timeout.
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic               err_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = $clog2(BEATS);
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      tcnt;
  logic [LINE_W-1:0]  wbuf;
  logic               err_q;
  logic               busy;
  logic               timed_out;

  assign busy      = (state == RD) || (state == WR);
  assign timed_out = (TIMEOUT > 0) && busy && !resp_i && (tcnt == T_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (read_i)       state_next = RD;
        else if (write_i) state_next = WR;
      end
      RD, WR: begin
        if ((resp_i && cnt == LAST) || timed_out) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      wbuf      <= '0;
      err_q     <= 1'b0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            address_o <= {address_i[ADDR_W-1:OFF], {OFF{1'b0}}};
            cnt       <= '0;
            tcnt      <= '0;
            err_q     <= 1'b0;
            if (!read_i) wbuf <= line_i;
          end
        end
        RD, WR: begin
          if (resp_i) begin
            // Beat 0 lands in the LSBs; untouched slices keep older data.
            if (state == RD) line_o[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (timed_out) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_o  = (state == RD);
  assign write_o = (state == WR);
  assign burst_o = (state == WR) ? wbuf[int'(cnt)*BURST_W +: BURST_W] : '0;
  assign resp_o  = (state == DONE);
  assign err_o   = (state == DONE) && err_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - scoreboard bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, err_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;

  logic [255:0] b_line_i, b_line_o;
  logic [31:0]  b_address_i, b_address_o;
  logic         b_read_i, b_write_i, b_resp_o, b_err_o, b_read_o, b_write_o, b_resp_i;
  logic [31:0]  b_burst_i, b_burst_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [255:0] model_line;

  always #5 clk = ~clk;

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .err_o(err_o), .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i));

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(32), .ADDR_W(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .line_i(b_line_i), .line_o(b_line_o),
    .address_i(b_address_i), .read_i(b_read_i), .write_i(b_write_i), .resp_o(b_resp_o),
    .err_o(b_err_o), .burst_i(b_burst_i), .burst_o(b_burst_o), .address_o(b_address_o),
    .read_o(b_read_o), .write_o(b_write_o), .resp_i(b_resp_i));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap, input bit both);
    read_i = 1'b1; write_i = both; address_i = addr;
    exp_line_q.push_back(line);
    tick();
    check("rd_addr", address_o, addr & ~32'h1f);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        check("rd_hold", {read_o, write_o}, 2'b10);
        tick();
      end
      check("rd_active", {read_o, write_o}, 2'b10);
      resp_i = 1'b1; burst_i = line[b*64 +: 64];
      tick();
      resp_i = 1'b0; burst_i = 64'($urandom());
    end
    model_line = line;
    check("rd_done", {resp_o, err_o, read_o, write_o}, 4'b1000);
    check("rd_line", line_o, exp_line_q.pop_front());
    read_i = 1'b0; write_i = 1'b0;
    tick();
    check("rd_resp_once", resp_o, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input logic [255:0] later, input int gap);
    write_i = 1'b1; address_i = addr; line_i = line;
    for (int b = 0; b < 4; b++) exp_beat_q.push_back(line[b*64 +: 64]);
    tick();
    line_i = later;
    check("wr_addr", address_o, addr & ~32'h1f);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        check("wr_hold", {write_o, read_o, 64'(burst_o)}, {2'b10, exp_beat_q[0]});
        tick();
      end
      check("wr_beat", {write_o, read_o, 64'(burst_o)}, {2'b10, exp_beat_q.pop_front()});
      resp_i = 1'b1;
      tick();
      resp_i = 1'b0;
    end
    check("wr_done", {resp_o, err_o, write_o, 64'(burst_o)}, {3'b100, 64'h0});
    write_i = 1'b0;
    tick();
    check("wr_resp_once", resp_o, 1'b0);
  endtask

  task automatic b_read(input logic [255:0] line, input int gap);
    b_read_i = 1'b1; b_address_i = 32'hdead_beef;
    exp_line_q.push_back(line);
    tick();
    check("b_addr", b_address_o, 32'hdead_bee0);
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gap; g++) tick();
      check("b_active", {b_read_o, b_resp_o}, 2'b10);
      b_resp_i = 1'b1; b_burst_i = line[b*32 +: 32];
      tick();
      b_resp_i = 1'b0;
    end
    check("b_done", {b_resp_o, b_err_o, b_read_o}, 3'b100);
    check("b_line", b_line_o, exp_line_q.pop_front());
    b_read_i = 1'b0;
    tick();
    check("b_resp_once", b_resp_o, 1'b0);
  endtask

  initial begin
    int n;
    logic [255:0] l_to;
    reset_n = 1'b0; line_i = '0; address_i = '0; read_i = 0; write_i = 0; resp_i = 0; burst_i = '0;
    b_line_i = '0; b_address_i = '0; b_read_i = 0; b_write_i = 0; b_resp_i = 0; b_burst_i = '0;
    model_line = '0;
    tick(); tick();
    check("reset_outs", {read_o, write_o, resp_o, err_o, burst_o, address_o}, '0);
    check("reset_line", line_o, '0);
    reset_n = 1'b1;
    tick();

    do_read(32'h1234_5678, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 0, 1'b0);
    do_write(32'h0000_103f, {64'hdddd_0004, 64'hcccc_0003, 64'hbbbb_0002, 64'haaaa_0001}, {4{64'hffff_ffff}}, 3);
    do_read(32'h8000_0040, {64'h4, 64'h3, 64'h2, 64'h1} ^ {8{32'ha5a5_5a5a}}, 1, 1'b1);

    // Stray memory acks while idle must not advance the beat counter.
    resp_i = 1'b1; tick(); tick(); resp_i = 1'b0;
    check("idle_ignore", {read_o, write_o, resp_o}, 3'b000);
    do_read(32'h0000_0020, {64'h0123, 64'h4567, 64'h89ab, 64'hcdef}, 0, 1'b0);

    // Two beats then silence: abort after 8 silent cycles with partial data kept.
    l_to = {64'h9999, 64'h8888, 64'h7777_0002, 64'h6666_0001};
    read_i = 1'b1; address_i = 32'h4000_0000;
    tick();
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = l_to[b*64 +: 64];
      tick();
    end
    resp_i = 1'b0;
    n = 0;
    while (!resp_o && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", n, 8);
    check("to_flags", {resp_o, err_o, read_o}, 3'b110);
    check("to_line", line_o, {model_line[255:128], l_to[127:0]});
    model_line = {model_line[255:128], l_to[127:0]};
    read_i = 1'b0;
    tick();
    check("to_pulse", {resp_o, err_o}, 2'b00);

    // Reset during the second write beat abandons the transaction.
    write_i = 1'b1; line_i = {4{64'h5555_aaaa}}; address_i = 32'h0000_0100;
    tick();
    resp_i = 1'b1; tick();
    reset_n = 1'b0; tick();
    reset_n = 1'b1; resp_i = 1'b0; write_i = 1'b0;
    check("rst_outs", {read_o, write_o, resp_o, err_o, burst_o, address_o}, '0);
    check("rst_line", line_o, '0);
    tick();
    check("rst_no_resp", resp_o, 1'b0);
    do_read(32'h0000_0abc, {64'hfeed, 64'hbeef, 64'hcafe, 64'hf00d}, 0, 1'b0);

    b_read(256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111, 0);
    b_read(256'h0f0f0f0f_1e1e1e1e_2d2d2d2d_3c3c3c3c_4b4b4b4b_5a5a5a5a_69696969_78787878, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
